// File: rtl/bpc_out_sched.sv
// rtl/bpc_out_sched.sv - block-granular scheduler from BPC code-buffer lanes to one 64-bit write port
//
// Grants one lane at a time for a whole compressed block, throttles it through
// lane_ready, drains its code words through a 4-deep skid FIFO to sequential
// word addresses, then issues one descriptor for the block. Round-robin
// arbitration happens only at block boundaries.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   lane_req         per-lane block pending (level, sampled only in IDLE)
//   lane_data        per-lane 64-bit code word, lane i at [64i+63:64i]
//   lane_dvalid      per-lane code word valid
//   lane_svalid      per-lane block size valid, marks end of block
//   lane_size        per-lane 11-bit block bit size, lane i at [11i+10:11i]
//   lane_ready       per-lane ready; only the granted lane is ever high
//   mem_wvalid/mem_waddr/mem_wdata/mem_wready   memory write port
//   desc_valid/desc_lane/desc_addr/desc_size/desc_nwords/desc_ready   descriptor
//   err              sticky protocol error
module bpc_out_sched #(
  parameter int NLANES = 4,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NLANES-1:0]      lane_req,
  input  logic [64*NLANES-1:0]   lane_data,
  input  logic [NLANES-1:0]      lane_dvalid,
  input  logic [NLANES-1:0]      lane_svalid,
  input  logic [11*NLANES-1:0]   lane_size,
  output logic [NLANES-1:0]      lane_ready,
  output logic                   mem_wvalid,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [63:0]            mem_wdata,
  input  logic                   mem_wready,
  output logic                   desc_valid,
  output logic [2:0]             desc_lane,
  output logic [ADDR_W-1:0]      desc_addr,
  output logic [10:0]            desc_size,
  output logic [3:0]             desc_nwords,
  input  logic                   desc_ready,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DESC   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        grant;
  logic [2:0]        last_grant;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [3:0]        nwords;
  logic [3:0]        npushed;
  logic [10:0]       size_q;

  logic [63:0]       fifo_mem [4];
  logic [1:0]        fifo_wr;
  logic [1:0]        fifo_rd;
  logic [2:0]        fifo_count;

  // Round-robin search starting just after the last granted lane.
  logic       arb_found;
  logic [2:0] arb_pick;

  always_comb begin
    arb_found = 1'b0;
    arb_pick  = 3'd0;
    for (int k = 1; k <= NLANES; k++) begin
      for (int i = 0; i < NLANES; i++) begin
        if (!arb_found && (i == ((int'(last_grant) + k) % NLANES)) && lane_req[i]) begin
          arb_found = 1'b1;
          arb_pick  = 3'(i);
        end
      end
    end
  end

  // Signals of the currently granted lane.
  logic [NLANES-1:0] grant_oh;
  logic [63:0]       g_data;
  logic              g_dvalid;
  logic              g_svalid;
  logic [10:0]       g_size;

  always_comb begin
    grant_oh = '0;
    g_data   = '0;
    g_dvalid = 1'b0;
    g_svalid = 1'b0;
    g_size   = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (grant == 3'(i)) begin
        grant_oh[i] = 1'b1;
        g_data      = lane_data[64*i +: 64];
        g_dvalid    = lane_dvalid[i];
        g_svalid    = lane_svalid[i];
        g_size      = lane_size[11*i +: 11];
      end
    end
  end

  logic              active;
  logic [NLANES-1:0] take_mask;
  logic              stray;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              err_set;

  assign active    = (state == ACTIVE);
  // Only the granted lane in ACTIVE may present words or sizes; anything else is a protocol error.
  assign take_mask = active ? grant_oh : '0;
  assign stray     = |((lane_dvalid | lane_svalid) & ~take_mask);

  assign mem_wvalid = (fifo_count != 3'd0);
  assign mem_waddr  = wr_ptr;
  assign mem_wdata  = fifo_mem[fifo_rd];
  assign pop        = mem_wvalid & mem_wready;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push_req = active & g_dvalid;
  assign push     = push_req & (npushed != 4'd8) & ((fifo_count != 3'd4) | pop);
  assign err_set  = stray | (push_req & ~push);

  assign desc_lane   = grant;
  assign desc_addr   = base;
  assign desc_size   = size_q;
  assign desc_nwords = nwords;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lane_ready = '0;
    desc_valid = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        // Two words can still be in flight from the registered code buffer
        // after ready falls, so ready only while at most one word is queued.
        if (fifo_count <= 3'd1) begin
          lane_ready = grant_oh;
        end
        if (g_svalid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == 3'd0) begin
          state_nxt = DESC;
        end
      end
      DESC: begin
        desc_valid = 1'b1;
        if (desc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 3'd0;
      last_grant <= 3'(NLANES - 1);
      wr_ptr     <= '0;
      base       <= '0;
      nwords     <= 4'd0;
      npushed    <= 4'd0;
      size_q     <= 11'd0;
      fifo_wr    <= 2'd0;
      fifo_rd    <= 2'd0;
      fifo_count <= 3'd0;
      err        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 64'd0;
      end
    end else begin
      if ((state == IDLE) && arb_found) begin
        grant   <= arb_pick;
        base    <= wr_ptr;
        nwords  <= 4'd0;
        npushed <= 4'd0;
      end

      if (active && g_svalid) begin
        size_q <= g_size;
      end

      if (push) begin
        fifo_mem[fifo_wr] <= g_data;
        fifo_wr           <= fifo_wr + 2'd1;
        npushed           <= npushed + 4'd1;
      end

      if (pop) begin
        fifo_rd <= fifo_rd + 2'd1;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        nwords  <= nwords + 4'd1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase

      if ((state == DESC) && desc_ready) begin
        last_grant <= grant;
      end

      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpc_out_sched.sv
// tb/tb_bpc_out_sched.sv - scoreboard bench for bpc_out_sched
module tb_bpc_out_sched;

  localparam int NL = 4;
  localparam int AW = 8;

  logic              clk;
  logic              rst_n;
  logic [NL-1:0]     lane_req;
  logic [64*NL-1:0]  lane_data;
  logic [NL-1:0]     lane_dvalid;
  logic [NL-1:0]     lane_svalid;
  logic [11*NL-1:0]  lane_size;
  logic [NL-1:0]     lane_ready;
  logic              mem_wvalid;
  logic [AW-1:0]     mem_waddr;
  logic [63:0]       mem_wdata;
  logic              mem_wready;
  logic              desc_valid;
  logic [2:0]        desc_lane;
  logic [AW-1:0]     desc_addr;
  logic [10:0]       desc_size;
  logic [3:0]        desc_nwords;
  logic              desc_ready;
  logic              err;

  bpc_out_sched #(.NLANES(NL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lane_req(lane_req), .lane_data(lane_data), .lane_dvalid(lane_dvalid),
    .lane_svalid(lane_svalid), .lane_size(lane_size), .lane_ready(lane_ready),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .desc_valid(desc_valid), .desc_lane(desc_lane), .desc_addr(desc_addr),
    .desc_size(desc_size), .desc_nwords(desc_nwords), .desc_ready(desc_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  typedef struct packed {
    logic [2:0]    lane;
    logic [AW-1:0] addr;
    logic [10:0]   size;
    logic [3:0]    nw;
  } desc_t;

  wr_t   exp_wr[$];
  desc_t exp_desc[$];
  int    checks = 0;
  int    errors = 0;

  // Code-buffer model state; stimulus writes the block contents and issued[],
  // the model owns everything else.
  logic [63:0]   blk_data [NL][8];
  int            blk_n [NL];
  logic [10:0]   blk_size [NL];
  int            issued [NL] = '{default: 0};
  int            taken [NL] = '{default: 0};
  int            idx [NL] = '{default: 0};
  bit            started [NL] = '{default: 0};
  int            inj_req = 0;
  int            inj_done = 0;
  int            wr_mode = 0;
  int            dr_mode = 0;
  int            cyc = 0;
  int            abort_lane = -1;
  logic [NL-1:0] rdy_s;
  logic [AW-1:0] exp_ptr = '0;
  int            blkno = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < NL; i++) begin
      if (issued[i] != taken[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic issue(input int ln, input int n, input logic [10:0] sz, input bit expect_out);
    logic [AW-1:0] b;
    logic [63:0]   d;
    b = exp_ptr;
    for (int k = 0; k < n; k++) begin
      d = {8'hD0, 8'(ln), 16'(blkno), 24'h0, 8'(k)};
      blk_data[ln][k] = d;
      if (expect_out) begin
        exp_wr.push_back('{addr: exp_ptr, data: d});
        exp_ptr = exp_ptr + AW'(1);
      end
    end
    blk_n[ln]    = n;
    blk_size[ln] = sz;
    if (expect_out) begin
      exp_desc.push_back('{lane: 3'(ln), addr: b, size: sz, nw: 4'(n)});
    end
    blkno++;
    issued[ln] = issued[ln] + 1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_wr.size() != 0 || exp_desc.size() != 0 || busy()) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, " completion"}, 64'(c < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Code-buffer model: ready seen during cycle t yields the next item during t+1.
  initial begin
    lane_req    = '0;
    lane_data   = '0;
    lane_dvalid = '0;
    lane_svalid = '0;
    lane_size   = '0;
    mem_wready  = 1'b1;
    desc_ready  = 1'b1;
    rdy_s       = '0;
    forever begin
      @(negedge clk);
      rdy_s = lane_ready;
      @(posedge clk);
      #1;
      cyc++;
      lane_dvalid = '0;
      lane_svalid = '0;
      if (!rst_n) begin
        for (int i = 0; i < NL; i++) begin
          taken[i]   = issued[i];
          started[i] = 1'b0;
          idx[i]     = 0;
        end
        lane_req = '0;
        inj_done = inj_req;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (issued[i] != taken[i] && rdy_s[i]) begin
            started[i] = 1'b1;
            if (blk_n[i] != 0) begin
              lane_data[64*i +: 64] = blk_data[i][idx[i]];
              lane_dvalid[i] = 1'b1;
              idx[i] = idx[i] + 1;
            end
            if (idx[i] == blk_n[i]) begin
              lane_svalid[i]        = 1'b1;
              lane_size[11*i +: 11] = blk_size[i];
              taken[i]   = taken[i] + 1;
              started[i] = 1'b0;
              idx[i]     = 0;
            end
          end
        end
        if (inj_req != inj_done) begin
          lane_data[64*3 +: 64] = 64'hBAD0_0000_0000_0BAD;
          lane_dvalid[3] = 1'b1;
          inj_done = inj_done + 1;
        end
        for (int i = 0; i < NL; i++) begin
          lane_req[i] = (issued[i] != taken[i]) && !started[i];
        end
      end
      case (wr_mode)
        1:       mem_wready = ((cyc % 4) == 0);
        2:       mem_wready = 1'b0;
        default: mem_wready = 1'b1;
      endcase
      desc_ready = (dr_mode == 1) ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  initial begin
    wr_t           w;
    desc_t         e;
    logic [NL-1:0] allowed;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wvalid && mem_wready) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_write_unexpected actual=%0h:%0h expected=none", mem_waddr, mem_wdata);
          end else begin
            w = exp_wr.pop_front();
            chk("mem_waddr", 64'(mem_waddr), 64'(w.addr));
            chk("mem_wdata", mem_wdata, w.data);
          end
        end
        if (desc_valid && desc_ready) begin
          if (exp_desc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL desc_unexpected actual=%0h expected=none",
                     {desc_lane, desc_addr, desc_size, desc_nwords});
          end else begin
            e = exp_desc.pop_front();
            chk("desc", 64'({desc_lane, desc_addr, desc_size, desc_nwords}), 64'(e));
          end
        end
        if (lane_ready != '0) begin
          if (exp_desc.size() != 0) allowed = NL'(1) << exp_desc[0].lane;
          else if (abort_lane >= 0) allowed = NL'(1) << abort_lane;
          else allowed = '0;
          chk("lane_ready_grant", 64'(lane_ready), 64'(allowed));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " lane_ready"}, 64'(lane_ready), 64'd0);
    chk({tag, " mem_wvalid"}, 64'(mem_wvalid), 64'd0);
    chk({tag, " mem_waddr"}, 64'(mem_waddr), 64'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, " desc_valid"}, 64'(desc_valid), 64'd0);
    chk({tag, " desc_fields"}, 64'({desc_lane, desc_addr, desc_size, desc_nwords}), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int n;
    int c;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single lane 0, eight words, size 512.
    issue(0, 8, 11'd512, 1'b1);
    wait_done("t1", 200);
    chk("t1 err", 64'(err), 64'd0);

    // Lanes 1 and 2 together after lane 0: lane 1 first, lane 2 at addr 8+3.
    issue(1, 3, 11'd192, 1'b1);
    issue(2, 2, 11'd100, 1'b1);
    wait_done("t2", 200);
    chk("t2 err", 64'(err), 64'd0);

    // Write port 1 cycle on, 3 off; slow descriptor accept.
    wr_mode = 1;
    dr_mode = 1;
    issue(3, 8, 11'd500, 1'b1);
    wait_done("t3", 400);
    wr_mode = 0;
    dr_mode = 0;
    chk("t3 err", 64'(err), 64'd0);

    // Empty block on lane 0 at wr_ptr 21.
    issue(0, 0, 11'd0, 1'b1);
    wait_done("t4", 100);
    chk("t4 wr_ptr", 64'(mem_waddr), 64'h15);
    chk("t4 err", 64'(err), 64'd0);

    // Advance wr_ptr to FE, then a 4-word block wrapping to 00,01.
    while (exp_ptr != 8'hFE) begin
      n = int'(8'hFE - exp_ptr);
      if (n > 8) n = 8;
      issue(0, n, 11'(n * 64), 1'b1);
      wait_done("fill", 200);
    end
    issue(1, 4, 11'd256, 1'b1);
    wait_done("t5", 200);
    chk("t5 wr_ptr", 64'(mem_waddr), 64'h02);
    chk("t5 err", 64'(err), 64'd0);

    // Stalled lane 0 block, stray word on lane 3, then reset mid-block.
    wr_mode    = 2;
    abort_lane = 0;
    issue(0, 6, 11'd384, 1'b0);
    c = 0;
    while (!lane_ready[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t6 grant lane0", 64'(lane_ready[0]), 64'd1);
    repeat (4) @(negedge clk);
    chk("t6 err before stray", 64'(err), 64'd0);
    inj_req = inj_req + 1;
    repeat (3) @(negedge clk);
    chk("t6 err after stray", 64'(err), 64'd1);
    chk("t6 mem_wvalid stalled", 64'(mem_wvalid), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wr_mode    = 0;
    abort_lane = -1;
    exp_ptr    = '0;
    repeat (3) @(negedge clk);
    chk("t6 no desc after reset", 64'(desc_valid), 64'd0);

    // Fresh block after reset starts at address 0.
    issue(0, 2, 11'd128, 1'b1);
    wait_done("t7", 100);
    chk("t7 err", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpc_out_sched.md
# bpc_out_sched

Block-granular scheduler between NLANES BPC code-buffer lanes and a single shared 64-bit memory write port. It grants one lane at a time for a whole compressed block, throttles that lane via its ready input, and drains its 64-bit code words through a small skid FIFO to sequential memory addresses. When the block finishes, it issues one descriptor carrying the lane, base address and bit size. Round-robin arbitration runs at block boundaries.

## Interface
- NLANES, 4, number of code-buffer lanes (2..8)
- ADDR_W, 16, memory word-address width (64-bit words)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- lane_req  in  NLANES  lane has a block pending; level, held until granted
- lane_data  in  64*NLANES  code word of lane i at bits [64i+63:64i]
- lane_dvalid  in  NLANES  code word valid, lane i
- lane_svalid  in  NLANES  block size valid, lane i; marks end of block
- lane_size  in  11*NLANES  block bit size of lane i, valid with lane_svalid
- lane_ready  out  NLANES  ready_i of each code buffer; only the granted lane is ever high
- mem_wvalid  out  1  write request
- mem_waddr  out  ADDR_W  word address
- mem_wdata  out  64  write data
- mem_wready  in  1  write accepted when mem_wvalid & mem_wready
- desc_valid  out  1  descriptor valid, held until desc_ready
- desc_lane  out  3  granted lane index
- desc_addr  out  ADDR_W  block base word address
- desc_size  out  11  block size in bits, copied from lane_size
- desc_nwords  out  4  words written for the block (0..8)
- desc_ready  in  1  descriptor accepted
- err  out  1  sticky protocol error

## Operation
- States: IDLE, ACTIVE, DRAIN, DESC.
- IDLE: if any lane_req is high, the arbiter picks the first requester found by searching from (last_grant+1) mod NLANES upward with wrap. It latches grant and base = wr_ptr, clears nwords, and moves to ACTIVE. last_grant resets to NLANES-1, so lane 0 has first priority.
- ACTIVE: lane_ready[grant] = (fifo_count <= 1). Every other lane_ready is 0.
  - Words with lane_dvalid[grant] are pushed into a 4-deep FIFO.
  - lane_svalid[grant] latches lane_size and moves the block to DRAIN. A word and svalid arriving in the same cycle are both taken.
- DRAIN: lane_ready is all 0. Stay in DRAIN until the FIFO is empty, then go to DESC.
- FIFO head drives mem_wdata, with mem_waddr = wr_ptr and mem_wvalid = (count != 0).
  - On each accepted write, wr_ptr increments modulo 2^ADDR_W (wraps with no error) and nwords increments.
  - Push and pop in the same cycle leave count unchanged.
- DESC: desc_valid = 1, with fields stable and held until desc_ready. On acceptance, last_grant takes the value of grant and the state returns to IDLE.
- A block with svalid and no words is legal: the descriptor has nwords = 0 and desc_addr = the current wr_ptr.
- err is set (sticky) on any of the following:
  - dvalid or svalid from a non-granted lane (the word is dropped)
  - a push when the FIFO is full (the word is dropped)
  - a 9th word in a block (the word is dropped)
- lane_req is sampled only in IDLE. Deassertion while a lane is granted is ignored.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - wr_ptr 0
  - last_grant NLANES-1
  - FIFO empty
- Arbitration: lane_req seen in IDLE at cycle t gives the grant at t+1, so lane_ready can first rise at t+1.
- Code-buffer output is registered. A word caused by lane_ready at cycle t arrives at t+1, so the FIFO must absorb up to 2 in-flight words after ready falls. The count ≤ 1 rule bounds occupancy at 3.
- A FIFO push at t gives the earliest mem_wvalid at t+1. With mem_wready held high, throughput is one word per cycle.
- svalid at t with an empty FIFO after push/pop: DRAIN at t+1, DESC at t+2 at the earliest.
- desc_valid to next grant: desc accepted at t gives IDLE at t+1 and the next grant at t+2.
- mem_wready low: the FIFO fills, lane_ready drops within 1 cycle, and no word is lost.
- Reset mid-block aborts everything immediately. There is no descriptor for the partial block, and wr_ptr returns to 0.

## Test plan
- Single lane 0, 8 words D0..D7, svalid with size 512, mem_wready = 1 -> writes at addresses 0..7 in order; descriptor {lane 0, addr 0, size 512, nwords 8}; err = 0.
- Lanes 1 and 2 request together with last_grant = 0 -> lane 1 is served first, then lane 2. The lane 2 descriptor addr equals lane 1's nwords. lane_ready[2] stays 0 throughout lane 1's block.
- mem_wready toggles 1 cycle on, 3 off during an 8-word block -> FIFO count never exceeds 3, all 8 words are written in order, err = 0.
- Empty block: svalid with size 0 and no dvalid -> descriptor nwords 0, addr = wr_ptr, no memory writes.
- wr_ptr = 2^ADDR_W-2, 4-word block -> addresses FFFE, FFFF, 0000, 0001; descriptor addr FFFE.
- dvalid on lane 3 while lane 0 is granted -> err = 1 and the word is dropped. Assert rst_n low mid-block -> all outputs 0, state IDLE, no descriptor issued.
